// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scanner
// Brief    : Time-multiplexed common-anode 7-segment driver with leading-zero
//            suppression, hex mode, decimal points and anti-ghost blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_supp,
    input  logic                    enable,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes
);

    localparam int c_presc_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_presc_w-1:0] c_blank      = c_presc_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    logic [c_presc_w-1:0]    r_presc;
    logic [c_idx_w-1:0]      r_index;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;

    logic [3:0]              w_cur;
    logic [NUM_DIGITS:0]     w_zchain;
    logic                    w_lz_blank;
    logic [NUM_DIGITS-1:0]   w_anode_sel;
    logic [6:0]              w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] code, input logic hex);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        if (!hex && code > 4'd9) begin
            seg = 7'b1111111;
        end
        return seg;
    endfunction

    // w_zchain[k] is high when every digit at or above k is zero with no dp lit
    assign w_zchain[NUM_DIGITS] = 1'b1;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
        assign w_zchain[k] = w_zchain[k+1] & (r_digits[4*k +: 4] == 4'd0) & ~r_dp[k];
    end

    assign w_cur      = r_digits[{r_index, 2'b00} +: 4];
    assign w_lz_blank = lz_supp && (r_index != '0) && w_zchain[r_index];
    assign w_seg      = w_lz_blank ? 7'b1111111 : f_decode(w_cur, hex_mode);

    always_comb begin
        w_anode_sel          = '1;
        w_anode_sel[r_index] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_index  <= '0;
            r_digits <= '0;
            r_dp     <= '0;
            segments <= 7'b1111111;
            dp       <= 1'b1;
            anodes   <= '1;
        end else begin
            if (r_presc == c_presc_last) begin
                r_presc <= '0;
                r_index <= (r_index == c_idx_last) ? '0 : r_index + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (load) begin
                r_digits <= digits_in;
                r_dp     <= dp_in;
            end
            // Segments keep decoding through the blank window so the anode is the only gate
            segments <= w_seg;
            dp       <= ~r_dp[r_index];
            anodes   <= (enable && r_presc >= c_blank) ? w_anode_sel : '1;
        end
    end

endmodule
`default_nettype wire
